// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the robot-side UART command receiver.
// Optional build macro UART_CMD_PARITY_EN selects 8E1 framing in uart_rx_bit_engine.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    localparam logic [7:0] CMD_STOP  = 8'h01;
    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h08;
    localparam logic [7:0] CMD_BRAKE = 8'h10;
    localparam logic [7:0] CMD_RIGHT = 8'h20;
    localparam logic [7:0] CMD_BACK  = 8'h80;

    localparam int unsigned MODE_MSB = 7;
    localparam int unsigned CODE_LSB = 3;
    localparam int unsigned PAD_W    = 3;

    function automatic logic [7:0] code_to_onehot(input logic [2:0] code);
        return 8'h01 << code;
    endfunction

endpackage

// File: rtl/uart_rx_bit_engine.sv
// UART bit engine: rx synchroniser, baud counter and frame FSM.
// Build macro UART_CMD_PARITY_EN adds an even-parity bit after the data bits.
module uart_rx_bit_engine
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_done,
    output logic       stop_ok,
    output logic       parity_ok
);

    localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    rx_state_t     state_next;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_q;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          stop_bit;
    logic          tick;
    logic          fall;

    assign tick = (baud_cnt == '0);
    // rx_q lags rx_s so a line stuck low never looks like a fresh start edge
    assign fall = rx_q & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (fall) state_next = START;
            START:   if (tick) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (tick && bit_cnt == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY:  if (tick) state_next = STOP;
            STOP:    if (tick) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            stop_bit <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (fall) baud_cnt <= HALF;
                end
                START, DATA, PARITY, STOP: begin
                    baud_cnt <= tick ? FULL : baud_cnt - 1'b1;
                    if (tick && state == DATA) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (tick && state == STOP) stop_bit <= rx_s;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_CMD_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (state == PARITY && tick) begin
            par_bit <= rx_s;
        end
    end
`endif

    always_comb begin
        byte_out  = shreg;
        byte_done = (state == DONE);
        stop_ok   = stop_bit;
`ifdef UART_CMD_PARITY_EN
        parity_ok = ~^{shreg, par_bit};
`else
        parity_ok = 1'b1;
`endif
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Robot command receiver: frame check, one-hot decode, valid/ready handshake and link watchdog.
// Build macro UART_CMD_PARITY_EN (handled in uart_rx_bit_engine) selects 8E1 framing.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned TIMEOUT_CLKS = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] cmd_onehot,
    output logic [1:0] cmd_mode,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] held_cmd,
    output logic       link_up,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned WD_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CLKS - 1);

    logic [7:0]      byte_out;
    logic            byte_done;
    logic            stop_ok;
    logic            parity_ok;
    logic            frame_good;
    logic            frame_bad;
    logic [7:0]      new_onehot;
    logic [WD_W-1:0] wd_cnt;

    uart_rx_bit_engine #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_out  (byte_out),
        .byte_done (byte_done),
        .stop_ok   (stop_ok),
        .parity_ok (parity_ok)
    );

    assign frame_good = byte_done && stop_ok && parity_ok && (byte_out[PAD_W-1:0] == '0);
    assign frame_bad  = byte_done && !frame_good;
    assign new_onehot = code_to_onehot(byte_out[CODE_LSB +: 3]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_onehot <= '0;
            cmd_mode   <= '0;
            cmd_valid  <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun   <= frame_good && cmd_valid && !cmd_ready;
            frame_err <= frame_bad;
            // a new frame wins over a simultaneous accept, keeping valid high
            if (frame_good) begin
                cmd_onehot <= new_onehot;
                cmd_mode   <= byte_out[MODE_MSB -: 2];
                cmd_valid  <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt   <= '0;
            held_cmd <= CMD_STOP;
            link_up  <= 1'b0;
        end else if (frame_good) begin
            wd_cnt   <= '0;
            held_cmd <= new_onehot;
            link_up  <= 1'b1;
        end else if (wd_cnt == WD_MAX) begin
            held_cmd <= CMD_STOP;
            link_up  <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule
